// File: rtl/mod_enc_mixcolumns.sv
// AES MixColumns stage: gathers four shifted rows, then emits four mixed columns (row-in / column-out transpose).
// Optional build macro MIXCOL_BYPASS_EN adds a bypass input that passes columns through unmixed (final round).
module mod_enc_mixcolumns #(
  parameter int          N    = 4,
  parameter logic [7:0]  POLY = 8'h1B
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0][7:0]   in_row,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0][7:0]   out_col,
  output logic [1:0]          col_idx,
  output logic                done
`ifdef MIXCOL_BYPASS_EN
  ,
  input  logic                bypass
`endif
);

  // Handshake: a row (column) moves on a rising edge where valid && ready;
  // out_valid/out_col are held unchanged until out_ready is seen.

  if (N != 4) begin : g_n_check
    $error("mod_enc_mixcolumns: N must be 4");
  end

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_EMIT    = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   row_cnt_q, row_cnt_d;
  logic [1:0]                   col_cnt_q, col_cnt_d;
  logic                         done_q, done_d;
  logic [N-1:0][N-1:0][7:0]     mem_q;   // mem_q[row][col]
  logic                         in_fire, out_fire;
  logic [N-1:0][7:0]            column, mixed;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
  endfunction

  assign in_fire  = in_valid  && in_ready;
  assign out_fire = out_valid && out_ready;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_COLLECT;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (in_fire && row_cnt_q == 2'd3)  state_d = S_EMIT;
      S_EMIT:    if (out_fire && col_cnt_q == 2'd3) state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == S_COLLECT);
    out_valid = (state_q == S_EMIT);
    col_idx   = col_cnt_q;
    done      = done_q;
  end

  // Counters wrap naturally at 3 -> 0
  always_comb begin
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    if (in_fire)  row_cnt_d = row_cnt_q + 2'd1;
    if (out_fire) col_cnt_d = col_cnt_q + 2'd1;
    done_d = out_fire && (col_cnt_q == 2'd3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt_q <= 2'd0;
      col_cnt_q <= 2'd0;
      done_q    <= 1'b0;
      mem_q     <= '0;
    end else begin
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      done_q    <= done_d;
      if (in_fire) mem_q[row_cnt_q] <= in_row;
    end
  end

`ifdef MIXCOL_BYPASS_EN
  logic bypass_q;

  // Bypass is latched with the last row so it stays constant for the whole block
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             bypass_q <= 1'b0;
    else if (in_fire && row_cnt_q == 2'd3) bypass_q <= bypass;
  end
`endif

  always_comb begin
    for (int r = 0; r < N; r++) column[r] = mem_q[r][col_cnt_q];
    mixed[0] = xtime(column[0]) ^ xtime(column[1]) ^ column[1] ^ column[2] ^ column[3];
    mixed[1] = column[0] ^ xtime(column[1]) ^ xtime(column[2]) ^ column[2] ^ column[3];
    mixed[2] = column[0] ^ column[1] ^ xtime(column[2]) ^ xtime(column[3]) ^ column[3];
    mixed[3] = xtime(column[0]) ^ column[0] ^ column[1] ^ column[2] ^ xtime(column[3]);
  end

  always_comb begin
    out_col = '0;
    if (state_q == S_EMIT) begin
`ifdef MIXCOL_BYPASS_EN
      out_col = bypass_q ? column : mixed;
`else
      out_col = mixed;
`endif
    end
  end

endmodule

// File: tb/tb_mod_enc_mixcolumns.sv
// Bench for mod_enc_mixcolumns: table of blocks streamed through a cycle-accurate
// handshake model with a column scoreboard, plus reset / stall / back-to-back sequences.
module tb_mod_enc_mixcolumns;

  localparam int NV = 12;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0][7:0]  in_row = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0][7:0]  out_col;
  logic [1:0]       col_idx;
  logic             done;
`ifdef MIXCOL_BYPASS_EN
  logic             bypass = 1'b0;
`endif

  mod_enc_mixcolumns dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .col_idx   (col_idx),
    .done      (done)
`ifdef MIXCOL_BYPASS_EN
    ,
    .bypass    (bypass)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][3:0][7:0] cols;  // cols[c][r]
    logic [3:0][3:0][7:0] exp;   // exp[c][r]
    bit                   byp;
  } vec_t;

  vec_t        vecs[NV];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [33:0] exp_q[$];
  bit          m_emit, m_done, m_fire, m_pop;
  int          m_row;
  int          prev_done;
  int          done_gaps[$];

  function automatic logic [3:0][7:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [3:0][7:0] mix_model(input logic [3:0][7:0] a);
    int circ[4];
    logic [3:0][7:0] o;
    circ = '{2, 3, 1, 1};
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        o[r] = o[r] ^ gmul(a[k], 8'(circ[(k - r + 4) % 4]));
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: model-based checks at negedge, then return just after posedge.
  task automatic tick();
    logic [33:0] e;
    bit popped3;
    @(negedge clk);
    check("status{in_ready,out_valid,done}", {61'd0, in_ready, out_valid, done},
          {61'd0, ~m_emit, m_emit, m_done});
    if (!m_emit) check("idle_out", {30'd0, col_idx, out_col}, 64'd0);
    if (m_emit && !out_ready && exp_q.size() > 0)
      check("hold_col", {30'd0, col_idx, out_col}, {30'd0, exp_q[0]});
    if (done === 1'b1) begin
      if (prev_done >= 0) done_gaps.push_back(cyc - prev_done);
      prev_done = cyc;
    end
    m_fire  = in_valid && !m_emit && !reset;
    m_pop   = 1'b0;
    popped3 = 1'b0;
    if (m_emit && out_ready && !reset) begin
      m_pop = 1'b1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL column: got %h with empty scoreboard (cycle %0d)", {col_idx, out_col}, cyc);
      end else begin
        e = exp_q.pop_front();
        check("column", {30'd0, col_idx, out_col}, {30'd0, e});
        if (e[33:32] == 2'd3) popped3 = 1'b1;
      end
    end
    m_done = popped3;
    if (popped3) m_emit = 1'b0;
    if (m_fire) begin
      if (m_row == 3) begin
        m_row  = 0;
        m_emit = 1'b1;
      end else begin
        m_row++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    m_emit = 1'b0;
    m_done = 1'b0;
    m_row  = 0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic push_block(input int blk);
    for (int c = 0; c < 4; c++)
      exp_q.push_back({c[1:0], vecs[blk].exp[c]});
  endtask

  task automatic run_blocks(input int first, input int count, input int gap,
                            input int stall_col, input int stall_len,
                            input int abort_rows, input int abort_pops);
    int blk, last, gap_cnt, stall_left, rows, pops, budget;
    bit aborted;
    blk = first; last = first + count; gap_cnt = 0; stall_left = stall_len;
    rows = 0; pops = 0; budget = 400; aborted = 1'b0;
    while (budget > 0) begin
      if (blk == last && !m_emit && exp_q.size() == 0) break;
      if ((abort_rows > 0 && rows >= abort_rows) || (abort_pops > 0 && pops >= abort_pops)) begin
        aborted = 1'b1;
        break;
      end
      in_valid = (blk < last) && (gap_cnt == 0);
      if (blk < last) begin
        for (int c = 0; c < 4; c++) in_row[c] = vecs[blk].cols[c][m_row];
`ifdef MIXCOL_BYPASS_EN
        bypass = (m_row == 3) ? vecs[blk].byp : ~vecs[blk].byp;
`endif
      end
      out_ready = 1'b1;
      if (m_emit && exp_q.size() > 0 && int'(exp_q[0][33:32]) == stall_col && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
      tick();
      budget--;
      if (m_fire) begin
        rows++;
        gap_cnt = gap;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
      if (m_pop) pops++;
      if (m_fire && m_emit) begin
        push_block(blk);
        blk++;
      end
    end
    in_valid = 1'b0;
    if (budget == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: block run did not complete in 400 cycles (cycle %0d)", cyc);
    end
    if (!aborted) begin
      out_ready = 1'b0;
      tick();  // observes the done pulse
    end
  endtask

  initial begin
    // Known vectors
    vecs[0].cols[0] = mk(8'hdb, 8'h13, 8'h53, 8'h45);
    vecs[0].cols[1] = mk(8'hf2, 8'h0a, 8'h22, 8'h5c);
    vecs[0].cols[2] = mk(8'h01, 8'h01, 8'h01, 8'h01);
    vecs[0].cols[3] = mk(8'h2d, 8'h26, 8'h31, 8'h4c);
    vecs[0].exp[0]  = mk(8'h8e, 8'h4d, 8'ha1, 8'hbc);
    vecs[0].exp[1]  = mk(8'h9f, 8'hdc, 8'h58, 8'h9d);
    vecs[0].exp[2]  = mk(8'h01, 8'h01, 8'h01, 8'h01);
    vecs[0].exp[3]  = mk(8'h4d, 8'h7e, 8'hbd, 8'hf8);
    vecs[0].byp     = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vecs[1].cols[c] = mk(8'hd4, 8'hd4, 8'hd4, 8'hd5);
      vecs[1].exp[c]  = mk(8'hd5, 8'hd5, 8'hd7, 8'hd6);
      vecs[2].cols[c] = '0;
      vecs[2].exp[c]  = '0;
      vecs[3].cols[c] = mk(8'hc6, 8'hc6, 8'hc6, 8'hc6);
      vecs[3].exp[c]  = mk(8'hc6, 8'hc6, 8'hc6, 8'hc6);
    end
    vecs[1].byp = 1'b0; vecs[2].byp = 1'b0; vecs[3].byp = 1'b0;
    // Random blocks, expected from the GF(2^8) matrix model
    for (int i = 4; i < 10; i++) begin
      for (int c = 0; c < 4; c++) begin
        vecs[i].cols[c] = $urandom();
        vecs[i].exp[c]  = mix_model(vecs[i].cols[c]);
      end
      vecs[i].byp = 1'b0;
    end
    vecs[10] = vecs[0];
    vecs[11] = vecs[0];
`ifdef MIXCOL_BYPASS_EN
    vecs[10].byp = 1'b1;
    vecs[10].exp = vecs[10].cols;
`endif

    prev_done = -1;
    m_emit = 1'b0; m_done = 1'b0; m_row = 0;
    do_reset(2);

    // Table sweep with varying input gaps and output stalls
    for (int i = 0; i < NV; i++)
      run_blocks(i, 1, i % 4, i % 4, i % 3, 0, 0);

    // Back-to-back: in_valid and out_ready held high, done every 8 cycles
    done_gaps.delete();
    prev_done = -1;
    run_blocks(1, 3, 0, -1, 0, 0, 0);
    check("b2b_done_count", done_gaps.size(), 2);
    foreach (done_gaps[k]) check("b2b_done_period", done_gaps[k], 8);

    // Input stall: 3 idle cycles between rows
    run_blocks(1, 1, 3, -1, 0, 0, 0);

    // Backpressure: 5 stalled cycles on column 2
    run_blocks(0, 1, 0, 2, 5, 0, 0);

    // Reset mid-COLLECT, then a full block starting at row 0
    run_blocks(0, 1, 0, -1, 0, 2, 0);
    do_reset(1);
    run_blocks(0, 1, 0, -1, 0, 0, 0);

    // Reset mid-EMIT after one column
    run_blocks(1, 1, 0, -1, 0, 0, 1);
    do_reset(1);
    run_blocks(0, 1, 1, -1, 0, 0, 0);

    // Random streams with random gaps and stalls
    for (int i = 0; i < 6; i++)
      run_blocks(4 + i, 1 + (i % 3 == 0 ? 1 : 0), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 4), 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
